wb_stage: RTL and testbench



---
 rtl/core_pkg.sv | 32 +++
 rtl/wb_stage_load_align.sv | 40 ++++
 rtl/wb_stage.sv | 168 ++++++++++++++++
 tb/tb_wb_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I multicycle core: widths, writeback select
// codes, load funct3 encodings and the writeback-stage state type.
package core_pkg;

  localparam int XLEN           = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    MEM_REQ,
    MEM_WAIT,
    WRITE
  } wb_state_t;

  function automatic logic is_legal_load(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// load_align: picks the addressed byte/halfword out of a memory word and
// sign/zero-extends it; also flags misaligned offsets and unknown funct3.
module load_align
  import core_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      offset_i,
  input  logic [XLEN-1:0] word_i,
  output logic [XLEN-1:0] result_o,
  output logic            misalign_o,
  output logic            illegal_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  assign byteSel   = word_i[{offset_i, 3'b000} +: 8];
  assign halfSel   = word_i[{offset_i[1], 4'b0000} +: 16];
  assign illegal_o = !is_legal_load(funct3_i);

  always_comb begin
    result_o   = word_i;
    misalign_o = 1'b0;
    case (funct3_i)
      F3_LB:  result_o = {{(XLEN-8){byteSel[7]}}, byteSel};
      F3_LBU: result_o = {{(XLEN-8){1'b0}}, byteSel};
      F3_LH: begin
        result_o   = {{(XLEN-16){halfSel[15]}}, halfSel};
        misalign_o = offset_i[0];
      end
      F3_LHU: begin
        result_o   = {{(XLEN-16){1'b0}}, halfSel};
        misalign_o = offset_i[0];
      end
      F3_LW:   misalign_o = |offset_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the RV32I multicycle core, driving the regfile
// write port. Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage
  import core_pkg::*;
#(
  parameter int XLEN           = core_pkg::XLEN,
  parameter int REG_ADDR_WIDTH = core_pkg::REG_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
  input  logic                      in_rd_we,
  input  logic [1:0]                in_wb_sel,
  input  logic [2:0]                in_funct3,
  input  logic [XLEN-1:0]           in_alu_result,
  input  logic [XLEN-1:0]           in_pc_plus4,
  output logic                      dmem_req_valid,
  input  logic                      dmem_req_ready,
  output logic [XLEN-1:0]           dmem_addr,
  input  logic                      dmem_rsp_valid,
  input  logic [XLEN-1:0]           dmem_rsp_data,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr,
  output logic [XLEN-1:0]           rd_data,
  output logic                      write_en,
  output logic                      done,
  output logic                      load_fault
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]               retire_count
`endif
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  wb_state_t                 state_q;
  logic                      in_ready_q, dmem_req_valid_q, write_en_q, done_q, load_fault_q;
  logic [XLEN-1:0]           dmem_addr_q, rd_data_q;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_q, rdAddrCap_q;
  logic                      rdWe_q;
  logic [2:0]                funct3_q;
  logic [1:0]                off_q;
  logic [15:0]               tmoCnt_q;

  logic [2:0]      alF3;
  logic [1:0]      alOff;
  logic [XLEN-1:0] alResult;
  logic            alMisalign, alIllegal;
  logic            isLoad, acceptToMem, tmoHit;

  // Alignment checks use the live inputs at accept and the captured fields while waiting.
  assign alF3        = (state_q == IDLE) ? in_funct3 : funct3_q;
  assign alOff       = (state_q == IDLE) ? in_alu_result[1:0] : off_q;
  assign isLoad      = (in_wb_sel == WB_LOAD);
  assign acceptToMem = isLoad && !alMisalign && !alIllegal;
  assign tmoHit      = (tmoCnt_q >= TMO_LAST);

  load_align u_align (
    .funct3_i   (alF3),
    .offset_i   (alOff),
    .word_i     (dmem_rsp_data),
    .result_o   (alResult),
    .misalign_o (alMisalign),
    .illegal_o  (alIllegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      in_ready_q       <= 1'b1;
      dmem_req_valid_q <= 1'b0;
      dmem_addr_q      <= '0;
      rd_addr_q        <= '0;
      rd_data_q        <= '0;
      write_en_q       <= 1'b0;
      done_q           <= 1'b0;
      load_fault_q     <= 1'b0;
      rdAddrCap_q      <= '0;
      rdWe_q           <= 1'b0;
      funct3_q         <= '0;
      off_q            <= '0;
      tmoCnt_q         <= '0;
    end else begin
      write_en_q   <= 1'b0;
      done_q       <= 1'b0;
      load_fault_q <= 1'b0;
      case (state_q)
        IDLE: if (in_valid) begin
          rdAddrCap_q <= in_rd_addr;
          rdWe_q      <= in_rd_we;
          funct3_q    <= in_funct3;
          off_q       <= in_alu_result[1:0];
          in_ready_q  <= 1'b0;
          if (acceptToMem) begin
            state_q          <= MEM_REQ;
            dmem_req_valid_q <= 1'b1;
            dmem_addr_q      <= {in_alu_result[XLEN-1:2], 2'b00};
            tmoCnt_q         <= '0;
          end else begin
            state_q      <= WRITE;
            done_q       <= 1'b1;
            load_fault_q <= isLoad;
            write_en_q   <= in_rd_we && (|in_rd_addr) && !isLoad;
            rd_addr_q    <= in_rd_addr;
            rd_data_q    <= (in_wb_sel == WB_PC4) ? in_pc_plus4 : in_alu_result;
          end
        end
        // The timeout wins over a late handshake so the budget is never exceeded.
        MEM_REQ: begin
          tmoCnt_q <= tmoCnt_q + 16'd1;
          if (tmoHit) begin
            state_q          <= WRITE;
            dmem_req_valid_q <= 1'b0;
            done_q           <= 1'b1;
            load_fault_q     <= 1'b1;
            rd_addr_q        <= rdAddrCap_q;
          end else if (dmem_req_ready) begin
            state_q          <= MEM_WAIT;
            dmem_req_valid_q <= 1'b0;
          end
        end
        MEM_WAIT: begin
          tmoCnt_q <= tmoCnt_q + 16'd1;
          if (dmem_rsp_valid) begin
            state_q    <= WRITE;
            done_q     <= 1'b1;
            write_en_q <= rdWe_q && (|rdAddrCap_q);
            rd_addr_q  <= rdAddrCap_q;
            rd_data_q  <= alResult;
          end else if (tmoHit) begin
            state_q      <= WRITE;
            done_q       <= 1'b1;
            load_fault_q <= 1'b1;
            rd_addr_q    <= rdAddrCap_q;
          end
        end
        WRITE: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready       = in_ready_q;
  assign dmem_req_valid = dmem_req_valid_q;
  assign dmem_addr      = dmem_addr_q;
  assign rd_addr        = rd_addr_q;
  assign rd_data        = rd_data_q;
  assign write_en       = write_en_q;
  assign done           = done_q;
  assign load_fault     = load_fault_q;

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retireCnt_q;

  always_ff @(posedge clk) begin
    if (rst) retireCnt_q <= '0;
    else if (done_q && !load_fault_q) retireCnt_q <= retireCnt_q + 64'd1;
  end

  assign retire_count = retireCnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed plus randomized checks of wb_stage against a
// behavioural model of the writeback rules, with a small in-bench memory.
module tb_wb_stage;
  import core_pkg::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_rd_we;
  logic [4:0]  in_rd_addr, rd_addr;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_result, in_pc_plus4, dmem_addr, dmem_rsp_data, rd_data;
  logic        dmem_req_valid, dmem_req_ready, dmem_rsp_valid;
  logic        write_en, done, load_fault;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_count;
  longint unsigned expRetire = 0;
`endif

  int total = 0;
  int bad   = 0;

  wb_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we), .in_wb_sel(in_wb_sel),
    .in_funct3(in_funct3), .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_addr(dmem_addr),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_data(dmem_rsp_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .write_en(write_en), .done(done),
    .load_fault(load_fault)
`ifdef WB_RETIRE_CNT_EN
    , .retire_count(retire_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Byte/halfword extraction done with shifts and arithmetic on the word.
  function automatic logic [31:0] extendLoad(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    int unsigned off = addr % 4;
    int unsigned b   = (word >> (8 * off)) & 32'hFF;
    int unsigned h   = (word >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'b101:  return h;
      default: return word;
    endcase
  endfunction

  // Issue one instruction at a negedge, play memory with the given delays, check the retire.
  task automatic applyStimulus(input logic [1:0] sel, input logic [2:0] f3, input logic [4:0] rd,
                               input logic we, input logic [31:0] alu, input logic [31:0] pc4,
                               input logic [31:0] word, input int reqD, input int rspD);
    logic [31:0] expVal = 32'h0;
    logic [31:0] seenAddr = 32'h0;
    logic        expFault;
    bit isLoad = (sel == 2'b01);
    bit legal  = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    bit mis    = ((f3 == 3'd1 || f3 == 3'd5) && alu[0]) || (f3 == 3'd2 && alu[1:0] != 2'b00);
    bit expReq = isLoad && legal && !mis;
    bit sawReq = 0;
    bit gotDone = 0;
    int expLat, lat = 0, reqW = 0, rspW = 0;

    if (!isLoad) begin
      expVal = (sel == 2'b10) ? pc4 : alu; expFault = 1'b0; expLat = 1;
    end else if (!expReq) begin
      expFault = 1'b1; expLat = 1;
    end else if (reqD + rspD + 2 > TMO) begin
      expFault = 1'b1; expLat = TMO + 1;
    end else begin
      expFault = 1'b0; expVal = extendLoad(f3, alu, word); expLat = reqD + rspD + 3;
    end

    checkOutput("in_ready_idle", 64'(in_ready), 64'(1));
    in_valid = 1'b1; in_wb_sel = sel; in_funct3 = f3; in_rd_addr = rd; in_rd_we = we;
    in_alu_result = alu; in_pc_plus4 = pc4;
    @(negedge clk);
    in_valid = 1'b0;
    in_alu_result = $urandom; in_pc_plus4 = $urandom; in_rd_addr = 5'($urandom);
    for (int c = 1; c <= 40; c++) begin
      dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_data = $urandom;
      if (done) begin lat = c; gotDone = 1; break; end
      if (dmem_req_valid) begin
        if (!sawReq) seenAddr = dmem_addr;
        sawReq = 1;
        if (reqW == reqD) dmem_req_ready = 1'b1; else reqW++;
      end else if (sawReq) begin
        if (rspW == rspD) begin dmem_rsp_valid = 1'b1; dmem_rsp_data = word; end
        rspW++;
      end
      @(negedge clk);
    end

    checkOutput("done_seen", 64'(gotDone), 64'(1));
    checkOutput("latency", 64'(lat), 64'(expLat));
    checkOutput("req_issued", 64'(sawReq), 64'(expReq));
    if (expReq) checkOutput("dmem_addr", 64'(seenAddr), 64'({alu[31:2], 2'b00}));
    checkOutput("load_fault", 64'(load_fault), 64'(expFault));
    checkOutput("write_en", 64'(write_en), 64'(we && rd != 5'd0 && !expFault));
    checkOutput("rd_addr", 64'(rd_addr), 64'(rd));
    if (!expFault) checkOutput("rd_data", 64'(rd_data), 64'(expVal));
    checkOutput("in_ready_write", 64'(in_ready), 64'(0));
`ifdef WB_RETIRE_CNT_EN
    if (!expFault) expRetire++;
`endif
    @(negedge clk);
    checkOutput("done_after", 64'(done), 64'(0));
    checkOutput("write_en_after", 64'(write_en), 64'(0));
    checkOutput("rd_addr_hold", 64'(rd_addr), 64'(rd));
    if (!expFault) checkOutput("rd_data_hold", 64'(rd_data), 64'(expVal));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rd_addr = '0; in_rd_we = 1'b0; in_wb_sel = '0;
    in_funct3 = '0; in_alu_result = '0; in_pc_plus4 = '0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
    checkOutput("rst_done", 64'(done), 64'(0));
    checkOutput("rst_write_en", 64'(write_en), 64'(0));
    checkOutput("rst_fault", 64'(load_fault), 64'(0));
    checkOutput("rst_req_valid", 64'(dmem_req_valid), 64'(0));
    checkOutput("rst_rd_data", 64'(rd_data), 64'(0));
    checkOutput("rst_rd_addr", 64'(rd_addr), 64'(0));
    checkOutput("rst_dmem_addr", 64'(dmem_addr), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed cases");
    applyStimulus(2'b00, 3'd0, 5'd5, 1'b1, 32'h1234, 32'h0, 32'h0, 0, 0);
    applyStimulus(2'b10, 3'd0, 5'd0, 1'b1, 32'hDEAD, 32'h104, 32'h0, 0, 0);
    applyStimulus(2'b01, 3'd0, 5'd7, 1'b1, 32'h203, 32'h0, 32'h80FF_FFFF, 0, 2);
    applyStimulus(2'b01, 3'd5, 5'd9, 1'b1, 32'h202, 32'h0, 32'hBEEF_1234, 0, 0);
    applyStimulus(2'b01, 3'd2, 5'd4, 1'b1, 32'h101, 32'h0, 32'h0, 0, 0);
    applyStimulus(2'b01, 3'd2, 5'd6, 1'b1, 32'h400, 32'h0, 32'h1111_2222, 0, 10);
    applyStimulus(2'b01, 3'd2, 5'd6, 1'b1, 32'h404, 32'h0, 32'h1111_2222, 3, 0);
    applyStimulus(2'b01, 3'd1, 5'd8, 1'b1, 32'h206, 32'h0, 32'h8001_7777, 1, 1);
    applyStimulus(2'b11, 3'd0, 5'd3, 1'b1, 32'hCAFE, 32'h55, 32'h0, 0, 0);
    applyStimulus(2'b01, 3'd6, 5'd2, 1'b1, 32'h300, 32'h0, 32'h0, 0, 0);

    $display("[TB] random cases");
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a = $urandom;
      applyStimulus(2'($urandom), 3'($urandom), 5'($urandom), 1'($urandom), a,
                    32'($urandom), 32'($urandom), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)));
    end
`ifdef WB_RETIRE_CNT_EN
    checkOutput("retire_count", retire_count, 64'(expRetire));
`endif

    $display("[TB] reset during MEM_WAIT");
    in_valid = 1'b1; in_wb_sel = 2'b01; in_funct3 = 3'd2; in_alu_result = 32'h300;
    in_rd_addr = 5'd3; in_rd_we = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("mw_req_valid", 64'(dmem_req_valid), 64'(1));
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mw_rst_ready", 64'(in_ready), 64'(1));
    checkOutput("mw_rst_req", 64'(dmem_req_valid), 64'(0));
    dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    checkOutput("late_rsp_we", 64'(write_en), 64'(0));
    checkOutput("late_rsp_done", 64'(done), 64'(0));
    checkOutput("late_rsp_ready", 64'(in_ready), 64'(1));

    $display("[TB] reset during MEM_REQ");
    in_valid = 1'b1; in_funct3 = 3'd4; in_alu_result = 32'h501;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("mr_req_valid", 64'(dmem_req_valid), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mr_rst_req", 64'(dmem_req_valid), 64'(0));
    checkOutput("mr_rst_ready", 64'(in_ready), 64'(1));
`ifdef WB_RETIRE_CNT_EN
    checkOutput("retire_count_rst", retire_count, 64'(0));
`endif
    @(negedge clk);
    applyStimulus(2'b00, 3'd0, 5'd31, 1'b1, 32'hA5A5_0001, 32'h0, 32'h0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
